// File: rtl/io_multi_deq_policy.sv
// In-order multi-lane allocate/dequeue controller for an issue-queue payload RAM; outputs are registered state, visible the cycle after a fire.
// Backpressure: enq_ready drops unless a full ENQ_WIDTH group fits; flush suppresses both enq and deq for its cycle.
module io_multi_deq_policy #(
   parameter int QUEUE_SIZE = 8,
   parameter int ENQ_WIDTH  = 2,
   parameter int DEQ_WIDTH  = 2,
   localparam int PTR_W     = $clog2(QUEUE_SIZE)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [QUEUE_SIZE-1:0]      flush_keep,
   input  logic [ENQ_WIDTH-1:0]       enq_valid,
   output logic                       enq_ready,
   output logic [ENQ_WIDTH*PTR_W-1:0] enq_idx,
   output logic [DEQ_WIDTH-1:0]       deq_valid,
   output logic [DEQ_WIDTH*PTR_W-1:0] deq_idx,
   input  logic [DEQ_WIDTH-1:0]       deq_fire,
   output logic [QUEUE_SIZE-1:0]      valid_vec,
   output logic [PTR_W:0]             count,
   output logic                       full,
   output logic                       empty
);

   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] Q_C   = CNT_W'(QUEUE_SIZE);
   localparam logic [CNT_W-1:0] ENQ_C = CNT_W'(ENQ_WIDTH);

   logic [PTR_W-1:0]      head, tail, head_nxt, tail_nxt;
   logic [CNT_W-1:0]      count_nxt, n_enq, n_deq, k_keep;
   logic [QUEUE_SIZE-1:0] vec_nxt;
   logic [DEQ_WIDTH-1:0]  deq_take;
   logic                  enq_run, deq_run;

   // base + off with off <= QUEUE_SIZE, so the sum stays below 2*QUEUE_SIZE and one subtract wraps it
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [CNT_W-1:0] off);
      logic [CNT_W-1:0] s;
      s = CNT_W'(base) + off;
      if (s >= Q_C) s = s - Q_C;
      return PTR_W'(s);
   endfunction

   always_comb begin
      enq_ready = ~flush & ((Q_C - count) >= ENQ_C);
      full      = (count == Q_C);
      empty     = (count == '0);
      enq_idx   = '0;
      deq_idx   = '0;
      deq_valid = '0;
      for (int i = 0; i < ENQ_WIDTH; i++)
         enq_idx[i*PTR_W +: PTR_W] = wrap_add(tail, CNT_W'(i));
      for (int k = 0; k < DEQ_WIDTH; k++) begin
         deq_idx[k*PTR_W +: PTR_W] = wrap_add(head, CNT_W'(k));
         deq_valid[k]              = ~flush & (count > CNT_W'(k));
      end
   end

   always_comb begin
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;
      vec_nxt   = valid_vec;
      n_enq     = '0;
      n_deq     = '0;
      k_keep    = '0;
      enq_run   = 1'b1;
      deq_run   = 1'b1;
      deq_take  = deq_fire & deq_valid;

      // only the leading run of lanes counts; anything past the first gap is dropped
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         if (enq_run && enq_valid[i] && enq_ready) n_enq = n_enq + CNT_W'(1);
         else                                       enq_run = 1'b0;
      end
      for (int k = 0; k < DEQ_WIDTH; k++) begin
         if (deq_run && deq_take[k]) n_deq = n_deq + CNT_W'(1);
         else                        deq_run = 1'b0;
      end

      if (flush) begin
         for (int j = 0; j < QUEUE_SIZE; j++)
            if (flush_keep[j] && valid_vec[j]) k_keep = k_keep + CNT_W'(1);
         vec_nxt   = '0;
         for (int j = 0; j < QUEUE_SIZE; j++)
            if (CNT_W'(j) < k_keep) vec_nxt[wrap_add(head, CNT_W'(j))] = 1'b1;
         count_nxt = k_keep;
         tail_nxt  = wrap_add(head, k_keep);
      end else begin
         for (int k = 0; k < DEQ_WIDTH; k++)
            if (CNT_W'(k) < n_deq) vec_nxt[wrap_add(head, CNT_W'(k))] = 1'b0;
         for (int i = 0; i < ENQ_WIDTH; i++)
            if (CNT_W'(i) < n_enq) vec_nxt[wrap_add(tail, CNT_W'(i))] = 1'b1;
         head_nxt  = wrap_add(head, n_deq);
         tail_nxt  = wrap_add(tail, n_enq);
         count_nxt = count + n_enq - n_deq;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         valid_vec <= '0;
      end else begin
         head      <= head_nxt;
         tail      <= tail_nxt;
         count     <= count_nxt;
         valid_vec <= vec_nxt;
      end
   end

endmodule

// File: tb/tb_io_multi_deq_policy.sv
// Directed bench for io_multi_deq_policy at Q=8, ENQ=2, DEQ=2; head/tail observed through deq_idx lane 0 and enq_idx lane 0.
module tb_io_multi_deq_policy;

   logic       clock = 1'b0;
   logic       reset, flush;
   logic [7:0] flush_keep;
   logic [1:0] enq_valid, deq_fire;
   logic       enq_ready;
   logic [5:0] enq_idx, deq_idx;
   logic [1:0] deq_valid;
   logic [7:0] valid_vec;
   logic [3:0] count;
   logic       full, empty;

   int vectors = 0;
   int miscompares = 0;

   io_multi_deq_policy #(.QUEUE_SIZE(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) dut (
      .clock(clock), .reset(reset), .flush(flush), .flush_keep(flush_keep),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_idx(enq_idx),
      .deq_valid(deq_valid), .deq_idx(deq_idx), .deq_fire(deq_fire),
      .valid_vec(valid_vec), .count(count), .full(full), .empty(empty)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle;
      flush = 0; flush_keep = 8'h00; enq_valid = 2'b00; deq_fire = 2'b00;
   endtask

   task automatic test_reset;
      idle(); reset = 1; tick(); reset = 0; #1;
      vectors++; if (count !== 4'd0)      begin $display("FAIL reset_count got %0d want 0", count); miscompares++; end
      vectors++; if (empty !== 1'b1)      begin $display("FAIL reset_empty got %b want 1", empty); miscompares++; end
      vectors++; if (full !== 1'b0)       begin $display("FAIL reset_full got %b want 0", full); miscompares++; end
      vectors++; if (valid_vec !== 8'h00) begin $display("FAIL reset_vec got %h want 00", valid_vec); miscompares++; end
      vectors++; if (deq_valid !== 2'b00) begin $display("FAIL reset_deq_valid got %b want 00", deq_valid); miscompares++; end
      vectors++; if (enq_ready !== 1'b1)  begin $display("FAIL reset_enq_ready got %b want 1", enq_ready); miscompares++; end
      vectors++; if (enq_idx !== {3'd1, 3'd0}) begin $display("FAIL reset_enq_idx got %h want %h", enq_idx, {3'd1, 3'd0}); miscompares++; end
   endtask

   task automatic test_fill;
      logic [5:0] exp_idx [4];
      exp_idx[0] = {3'd1, 3'd0}; exp_idx[1] = {3'd3, 3'd2};
      exp_idx[2] = {3'd5, 3'd4}; exp_idx[3] = {3'd7, 3'd6};
      for (int c = 0; c < 4; c++) begin
         enq_valid = 2'b11; #1;
         vectors++; if (enq_idx !== exp_idx[c]) begin $display("FAIL fill_enq_idx[%0d] got %h want %h", c, enq_idx, exp_idx[c]); miscompares++; end
         tick();
         if (c == 2) begin
            vectors++; if (count !== 4'd6)     begin $display("FAIL fill_count6 got %0d want 6", count); miscompares++; end
            vectors++; if (enq_ready !== 1'b1) begin $display("FAIL fill_ready6 got %b want 1", enq_ready); miscompares++; end
         end
      end
      idle(); #1;
      vectors++; if (count !== 4'd8)      begin $display("FAIL fill_count8 got %0d want 8", count); miscompares++; end
      vectors++; if (full !== 1'b1)       begin $display("FAIL fill_full got %b want 1", full); miscompares++; end
      vectors++; if (enq_ready !== 1'b0)  begin $display("FAIL fill_ready8 got %b want 0", enq_ready); miscompares++; end
      vectors++; if (valid_vec !== 8'hFF) begin $display("FAIL fill_vec got %h want FF", valid_vec); miscompares++; end
   endtask

   task automatic test_drain_wrap;
      logic [5:0] exp_idx [3];
      exp_idx[0] = {3'd1, 3'd0}; exp_idx[1] = {3'd3, 3'd2}; exp_idx[2] = {3'd5, 3'd4};
      for (int c = 0; c < 3; c++) begin
         deq_fire = 2'b11; #1;
         vectors++; if (deq_idx !== exp_idx[c]) begin $display("FAIL drain_deq_idx[%0d] got %h want %h", c, deq_idx, exp_idx[c]); miscompares++; end
         vectors++; if (deq_valid !== 2'b11)    begin $display("FAIL drain_deq_valid[%0d] got %b want 11", c, deq_valid); miscompares++; end
         tick();
      end
      idle(); #1;
      vectors++; if (count !== 4'd2) begin $display("FAIL drain_count got %0d want 2", count); miscompares++; end
      vectors++; if (deq_idx !== {3'd7, 3'd6}) begin $display("FAIL drain_head got %h want %h", deq_idx, {3'd7, 3'd6}); miscompares++; end
      vectors++; if (enq_idx !== {3'd1, 3'd0}) begin $display("FAIL wrap_enq_idx got %h want %h", enq_idx, {3'd1, 3'd0}); miscompares++; end
      enq_valid = 2'b11; tick(); idle(); #1;
      vectors++; if (count !== 4'd4)      begin $display("FAIL wrap_count got %0d want 4", count); miscompares++; end
      vectors++; if (valid_vec !== 8'hC3) begin $display("FAIL wrap_vec got %h want C3", valid_vec); miscompares++; end
   endtask

   task automatic test_simul;
      deq_fire = 2'b01; tick(); idle(); #1;
      vectors++; if (count !== 4'd3)      begin $display("FAIL simul_pre_count got %0d want 3", count); miscompares++; end
      vectors++; if (valid_vec !== 8'h83) begin $display("FAIL simul_pre_vec got %h want 83", valid_vec); miscompares++; end
      enq_valid = 2'b11; deq_fire = 2'b01; #1;
      vectors++; if (enq_idx !== {3'd3, 3'd2}) begin $display("FAIL simul_enq_idx got %h want %h", enq_idx, {3'd3, 3'd2}); miscompares++; end
      vectors++; if (deq_idx[2:0] !== 3'd7)    begin $display("FAIL simul_deq_idx got %0d want 7", deq_idx[2:0]); miscompares++; end
      tick(); idle(); #1;
      vectors++; if (count !== 4'd4)      begin $display("FAIL simul_count got %0d want 4", count); miscompares++; end
      vectors++; if (valid_vec !== 8'h0F) begin $display("FAIL simul_vec got %h want 0F", valid_vec); miscompares++; end
      vectors++; if (deq_idx[2:0] !== 3'd0) begin $display("FAIL simul_head got %0d want 0", deq_idx[2:0]); miscompares++; end
      vectors++; if (enq_idx[2:0] !== 3'd4) begin $display("FAIL simul_tail got %0d want 4", enq_idx[2:0]); miscompares++; end
   endtask

   task automatic test_flush;
      idle(); reset = 1; tick(); reset = 0;
      for (int c = 0; c < 3; c++) begin enq_valid = 2'b11; tick(); end
      idle();
      for (int c = 0; c < 3; c++) begin deq_fire = 2'b11; tick(); end
      idle();
      for (int c = 0; c < 2; c++) begin enq_valid = 2'b11; tick(); end
      enq_valid = 2'b01; tick(); idle(); #1;
      vectors++; if (count !== 4'd5)      begin $display("FAIL flush_pre_count got %0d want 5", count); miscompares++; end
      vectors++; if (valid_vec !== 8'hC7) begin $display("FAIL flush_pre_vec got %h want C7", valid_vec); miscompares++; end
      flush = 1; flush_keep = 8'hC1; enq_valid = 2'b11; deq_fire = 2'b11; #1;
      vectors++; if (enq_ready !== 1'b0)  begin $display("FAIL flush_enq_ready got %b want 0", enq_ready); miscompares++; end
      vectors++; if (deq_valid !== 2'b00) begin $display("FAIL flush_deq_valid got %b want 00", deq_valid); miscompares++; end
      tick(); idle(); #1;
      vectors++; if (count !== 4'd3)        begin $display("FAIL flush_count got %0d want 3", count); miscompares++; end
      vectors++; if (valid_vec !== 8'hC1)   begin $display("FAIL flush_vec got %h want C1", valid_vec); miscompares++; end
      vectors++; if (enq_idx[2:0] !== 3'd1) begin $display("FAIL flush_tail got %0d want 1", enq_idx[2:0]); miscompares++; end
      vectors++; if (deq_idx[2:0] !== 3'd6) begin $display("FAIL flush_head got %0d want 6", deq_idx[2:0]); miscompares++; end
   endtask

   task automatic test_nonprefix_empty;
      enq_valid = 2'b01; tick(); idle();
      deq_fire = 2'b10; tick(); idle(); #1;
      vectors++; if (count !== 4'd4)        begin $display("FAIL nonprefix_count got %0d want 4", count); miscompares++; end
      vectors++; if (deq_idx[2:0] !== 3'd6) begin $display("FAIL nonprefix_head got %0d want 6", deq_idx[2:0]); miscompares++; end
      for (int c = 0; c < 2; c++) begin deq_fire = 2'b11; tick(); end
      idle(); #1;
      vectors++; if (empty !== 1'b1)      begin $display("FAIL drain_empty got %b want 1", empty); miscompares++; end
      deq_fire = 2'b11; #1;
      vectors++; if (deq_valid !== 2'b00) begin $display("FAIL empty_deq_valid got %b want 00", deq_valid); miscompares++; end
      tick(); idle(); #1;
      vectors++; if (count !== 4'd0)        begin $display("FAIL empty_count got %0d want 0", count); miscompares++; end
      vectors++; if (deq_idx[2:0] !== 3'd2) begin $display("FAIL empty_head got %0d want 2", deq_idx[2:0]); miscompares++; end
   endtask

   task automatic test_reset_mid;
      for (int c = 0; c < 2; c++) begin enq_valid = 2'b11; tick(); end
      enq_valid = 2'b01; tick(); idle(); #1;
      vectors++; if (count !== 4'd5) begin $display("FAIL mid_pre_count got %0d want 5", count); miscompares++; end
      reset = 1; flush = 1; flush_keep = 8'hFF; enq_valid = 2'b11; deq_fire = 2'b11;
      tick(); reset = 0; idle(); #1;
      vectors++; if (count !== 4'd0)      begin $display("FAIL mid_count got %0d want 0", count); miscompares++; end
      vectors++; if (valid_vec !== 8'h00) begin $display("FAIL mid_vec got %h want 00", valid_vec); miscompares++; end
      vectors++; if (empty !== 1'b1)      begin $display("FAIL mid_empty got %b want 1", empty); miscompares++; end
      vectors++; if (enq_ready !== 1'b1)  begin $display("FAIL mid_enq_ready got %b want 1", enq_ready); miscompares++; end
      vectors++; if (deq_idx[2:0] !== 3'd0) begin $display("FAIL mid_head got %0d want 0", deq_idx[2:0]); miscompares++; end
      vectors++; if (enq_idx[2:0] !== 3'd0) begin $display("FAIL mid_tail got %0d want 0", enq_idx[2:0]); miscompares++; end
   endtask

   initial begin
      reset = 1; idle();
      tick();
      test_reset();
      test_fill();
      test_drain_wrap();
      test_simul();
      test_flush();
      test_nonprefix_empty();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
